// File: rtl/panda_risc_v_dispatch_pkg.sv
// Shared constants and payload structs for the dispatch stage.
// Error codes, EXU slot indices, ALU message field offsets.
package panda_risc_v_dispatch_pkg;

  localparam logic [2:0] ERR_NORMAL             = 3'b000;
  localparam logic [2:0] ERR_ILLEGAL_INST       = 3'b001;
  localparam logic [2:0] ERR_ECALL              = 3'b010;
  localparam logic [2:0] ERR_EBREAK             = 3'b011;
  localparam logic [2:0] ERR_LD_ADDR_UNALIGNED  = 3'b110;
  localparam logic [2:0] ERR_STR_ADDR_UNALIGNED = 3'b111;
  localparam int         ERR_MISALIGN_BIT       = 2;

  localparam int EXU_LSU = 0;
  localparam int EXU_CSR = 1;
  localparam int EXU_MUL = 2;
  localparam int EXU_DIV = 3;

  localparam int OP_MODE_OFS = 64;
  localparam int OP1_OFS     = 32;
  localparam int OP2_OFS     = 0;

  // Sideband carried next to the message in the ALU slot.
  typedef struct packed {
    logic [2:0] err_code;
    logic [4:0] rd_id;
    logic       rd_vld;
    logic       is_long;
  } alu_meta_t;

  // Sideband in an EXU slot; tracked = this entry owns a busy bit and a long_cnt unit.
  typedef struct packed {
    logic [4:0] rd_id;
    logic       tracked;
  } exu_meta_t;

  function automatic logic is_misaligned(input logic [2:0] err_code);
    return err_code[ERR_MISALIGN_BIT];
  endfunction

endpackage

// File: rtl/panda_risc_v_dispatch_slot.sv
// One-entry output register slice with flush.
// Latency 1 cycle; load only when free (~out_vld | out_rdy), payload held while out_rdy is low.
module panda_risc_v_dispatch_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  output logic         free
);

  assign free = ~out_vld | out_rdy;

  // The data register is only written on load, so a stalled payload cannot move.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (load) begin
      out_vld <= 1'b1;
      out_dat <= load_dat;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/panda_risc_v_dispatch_stage.sv
// Dispatch stage: ALU slot + EXU_N aux slots, RD scoreboard for WAW, long_cnt cap, flush.
// Latency 1 cycle; s_dsp_ready drops on flush, WAW hazard, long cap or a busy target slot.
// Option: PANDA_RISC_V_DISPATCH_RETIRE_BYPASS_EN lets a retire release stalls in the same cycle.
module panda_risc_v_dispatch_stage
  import panda_risc_v_dispatch_pkg::*;
#(
  parameter int EXU_N    = 4,
  parameter int MSG_W    = 71,
  parameter int LONG_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [MSG_W-1:0]       s_dsp_msg,
  input  logic [EXU_N-1:0]       s_dsp_exu_sel,
  input  logic                   s_dsp_is_long,
  input  logic [4:0]             s_dsp_rd_id,
  input  logic                   s_dsp_rd_vld,
  input  logic [2:0]             s_dsp_err_code,
  input  logic                   s_dsp_valid,
  output logic                   s_dsp_ready,
  output logic [MSG_W-1:0]       m_alu_msg,
  output logic [2:0]             m_alu_err_code,
  output logic [4:0]             m_alu_rd_id,
  output logic                   m_alu_rd_vld,
  output logic                   m_alu_is_long,
  output logic                   m_alu_valid,
  input  logic                   m_alu_ready,
  output logic [EXU_N*MSG_W-1:0] m_exu_msg,
  output logic [EXU_N*5-1:0]     m_exu_rd_id,
  output logic [EXU_N-1:0]       m_exu_valid,
  input  logic [EXU_N-1:0]       m_exu_ready,
  input  logic                   retire_valid,
  input  logic [4:0]             retire_rd_id,
  output logic [3:0]             long_cnt
);

  localparam int         ALU_W      = MSG_W + $bits(alu_meta_t);
  localparam int         EXU_W      = MSG_W + $bits(exu_meta_t);
  localparam logic [3:0] LONG_MAX_C = 4'(LONG_MAX);

  logic [31:0]      busy;
  logic [31:0]      busy_n;
  logic [3:0]       long_cnt_n;
  logic [4:0]       drop_cnt;
  logic [4:0]       cnt_add;
  logic [4:0]       cnt_sub;

  logic             alu_free;
  logic [EXU_N-1:0] exu_free;
  logic [ALU_W-1:0] alu_dat;
  alu_meta_t        alu_meta_d;
  alu_meta_t        alu_meta_q;
  exu_meta_t        exu_meta_d;
  exu_meta_t        exu_meta [EXU_N];

  logic             rd_nz;
  logic             to_exu;
  logic             sel_free;
  logic             ret_eff;
  logic             ret_clr_hit;
  logic             cap_ok;
  logic             waw;
  logic             accept;
  logic             track_set;

  assign rd_nz   = s_dsp_rd_id != 5'd0;
  // A misaligned L/S is reported through the ALU path only.
  assign to_exu  = (|s_dsp_exu_sel) & ~is_misaligned(s_dsp_err_code);
  assign sel_free = ~to_exu | (|(s_dsp_exu_sel & exu_free));
  assign ret_eff = retire_valid & (long_cnt != 4'd0);

`ifdef PANDA_RISC_V_DISPATCH_RETIRE_BYPASS_EN
  assign ret_clr_hit = ret_eff & (retire_rd_id == s_dsp_rd_id);
  assign cap_ok      = (long_cnt < LONG_MAX_C) | ret_eff;
`else
  assign ret_clr_hit = 1'b0;
  assign cap_ok      = long_cnt < LONG_MAX_C;
`endif

  assign waw = s_dsp_rd_vld & rd_nz & busy[s_dsp_rd_id] & ~ret_clr_hit;

  assign s_dsp_ready = ~rst & ~flush & ~waw & (~s_dsp_is_long | cap_ok) & alu_free & sel_free;
  assign accept      = s_dsp_valid & s_dsp_ready;
  assign track_set   = accept & to_exu & exu_meta_d.tracked;

  assign alu_meta_d.err_code = s_dsp_err_code;
  assign alu_meta_d.rd_id    = s_dsp_rd_id;
  assign alu_meta_d.rd_vld   = s_dsp_rd_vld;
  assign alu_meta_d.is_long  = s_dsp_is_long;

  assign exu_meta_d.rd_id    = s_dsp_rd_id;
  assign exu_meta_d.tracked  = s_dsp_is_long & s_dsp_rd_vld & rd_nz;

  panda_risc_v_dispatch_slot #(.W(ALU_W)) u_alu_slot (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (accept),
    .load_dat ({s_dsp_msg, alu_meta_d}),
    .out_rdy  (m_alu_ready),
    .out_vld  (m_alu_valid),
    .out_dat  (alu_dat),
    .free     (alu_free)
  );

  assign {m_alu_msg, alu_meta_q} = alu_dat;
  assign m_alu_err_code = alu_meta_q.err_code;
  assign m_alu_rd_id    = alu_meta_q.rd_id;
  assign m_alu_rd_vld   = alu_meta_q.rd_vld;
  assign m_alu_is_long  = alu_meta_q.is_long;

  for (genvar k = 0; k < EXU_N; k++) begin : g_exu
    logic [EXU_W-1:0] dat_q;

    panda_risc_v_dispatch_slot #(.W(EXU_W)) u_exu_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (accept & to_exu & s_dsp_exu_sel[k]),
      .load_dat ({s_dsp_msg, exu_meta_d}),
      .out_rdy  (m_exu_ready[k]),
      .out_vld  (m_exu_valid[k]),
      .out_dat  (dat_q),
      .free     (exu_free[k])
    );

    assign {m_exu_msg[k*MSG_W +: MSG_W], exu_meta[k]} = dat_q;
    assign m_exu_rd_id[k*5 +: 5] = exu_meta[k].rd_id;
  end

  // Scoreboard update: retire and flushed entries clear, a new long entry sets and wins.
  always_comb begin
    busy_n   = busy;
    drop_cnt = '0;
    if (ret_eff) busy_n[retire_rd_id] = 1'b0;
    for (int k = 0; k < EXU_N; k++) begin
      if (flush & m_exu_valid[k] & ~m_exu_ready[k] & exu_meta[k].tracked) begin
        busy_n[exu_meta[k].rd_id] = 1'b0;
        drop_cnt = drop_cnt + 5'd1;
      end
    end
    if (track_set) busy_n[s_dsp_rd_id] = 1'b1;
  end

  assign cnt_add    = {1'b0, long_cnt} + {4'd0, track_set};
  assign cnt_sub    = drop_cnt + {4'd0, ret_eff};
  assign long_cnt_n = (cnt_sub > cnt_add) ? 4'd0 : 4'(cnt_add - cnt_sub);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      long_cnt <= '0;
    end else begin
      busy     <= busy_n;
      long_cnt <= long_cnt_n;
    end
  end

  retire_without_long: assert property (@(posedge clk) disable iff (rst)
    !(retire_valid && long_cnt == 4'd0));

endmodule

// File: tb/tb_panda_risc_v_dispatch_stage.sv
// Directed bench for panda_risc_v_dispatch_stage with queue scoreboard and decoupled monitor.
module tb_panda_risc_v_dispatch_stage;
  import panda_risc_v_dispatch_pkg::*;

  localparam int EXU_N    = 4;
  localparam int MSG_W    = 71;
  localparam int LONG_MAX = 4;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic [MSG_W-1:0]       s_dsp_msg;
  logic [EXU_N-1:0]       s_dsp_exu_sel;
  logic                   s_dsp_is_long;
  logic [4:0]             s_dsp_rd_id;
  logic                   s_dsp_rd_vld;
  logic [2:0]             s_dsp_err_code;
  logic                   s_dsp_valid;
  logic                   s_dsp_ready;
  logic [MSG_W-1:0]       m_alu_msg;
  logic [2:0]             m_alu_err_code;
  logic [4:0]             m_alu_rd_id;
  logic                   m_alu_rd_vld;
  logic                   m_alu_is_long;
  logic                   m_alu_valid;
  logic                   m_alu_ready;
  logic [EXU_N*MSG_W-1:0] m_exu_msg;
  logic [EXU_N*5-1:0]     m_exu_rd_id;
  logic [EXU_N-1:0]       m_exu_valid;
  logic [EXU_N-1:0]       m_exu_ready;
  logic                   retire_valid;
  logic [4:0]             retire_rd_id;
  logic [3:0]             long_cnt;

  panda_risc_v_dispatch_stage #(.EXU_N(EXU_N), .MSG_W(MSG_W), .LONG_MAX(LONG_MAX)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_dsp_msg(s_dsp_msg), .s_dsp_exu_sel(s_dsp_exu_sel), .s_dsp_is_long(s_dsp_is_long),
    .s_dsp_rd_id(s_dsp_rd_id), .s_dsp_rd_vld(s_dsp_rd_vld), .s_dsp_err_code(s_dsp_err_code),
    .s_dsp_valid(s_dsp_valid), .s_dsp_ready(s_dsp_ready),
    .m_alu_msg(m_alu_msg), .m_alu_err_code(m_alu_err_code), .m_alu_rd_id(m_alu_rd_id),
    .m_alu_rd_vld(m_alu_rd_vld), .m_alu_is_long(m_alu_is_long),
    .m_alu_valid(m_alu_valid), .m_alu_ready(m_alu_ready),
    .m_exu_msg(m_exu_msg), .m_exu_rd_id(m_exu_rd_id),
    .m_exu_valid(m_exu_valid), .m_exu_ready(m_exu_ready),
    .retire_valid(retire_valid), .retire_rd_id(retire_rd_id), .long_cnt(long_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [80:0] alu_q [$];
  logic [75:0] exu_q [EXU_N][$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chkp(input string name, input logic [80:0] act, input logic [80:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [MSG_W-1:0] mk(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [MSG_W-1:0] m;
    m = '0;
    m[OP_MODE_OFS +: 7] = 7'(op);
    m[OP1_OFS +: 32]    = a;
    m[OP2_OFS +: 32]    = b;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [MSG_W-1:0] msg, input logic [3:0] sel, input logic lng,
                       input logic [4:0] rd, input logic rv, input logic [2:0] err);
    s_dsp_msg      = msg;
    s_dsp_exu_sel  = sel;
    s_dsp_is_long  = lng;
    s_dsp_rd_id    = rd;
    s_dsp_rd_vld   = rv;
    s_dsp_err_code = err;
    s_dsp_valid    = 1'b1;
  endtask

  // Expected routing: ALU always, selected EXU unless the access is misaligned.
  task automatic push_cur();
    alu_q.push_back({s_dsp_msg, s_dsp_err_code, s_dsp_rd_id, s_dsp_rd_vld, s_dsp_is_long});
    if (s_dsp_exu_sel != 4'd0 && !s_dsp_err_code[2])
      for (int k = 0; k < EXU_N; k++)
        if (s_dsp_exu_sel[k]) exu_q[k].push_back({s_dsp_msg, s_dsp_rd_id});
  endtask

  task automatic send(input logic [MSG_W-1:0] msg, input logic [3:0] sel, input logic lng,
                      input logic [4:0] rd, input logic rv, input logic [2:0] err, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    drive(msg, sel, lng, rd, rv, err);
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (s_dsp_ready) begin
        push_cur();
        done = 1'b1;
      end else begin
        stalls++;
      end
      step();
    end
    if (!done) chk("send_timeout", stalls, 0);
    s_dsp_valid = 1'b0;
  endtask

  task automatic retire(input logic [4:0] rd);
    retire_valid = 1'b1;
    retire_rd_id = rd;
    step();
    retire_valid = 1'b0;
  endtask

  // Monitor: compare on each handshake, drop flushed entries, check held payloads.
  logic [80:0] mon_alu;
  logic [80:0] alu_prev;
  bit          alu_held;
  logic [80:0] mon_exu;
  logic [75:0] exu_pop;
  logic [80:0] exu_prev [EXU_N];
  bit          exu_held [EXU_N];

  always @(negedge clk) begin
    if (!rst) begin
      mon_alu = {m_alu_msg, m_alu_err_code, m_alu_rd_id, m_alu_rd_vld, m_alu_is_long};
      if (alu_held) begin
        chk("alu_hold_vld", int'(m_alu_valid), 1);
        chkp("alu_hold_dat", mon_alu, alu_prev);
      end
      if (m_alu_valid && (m_alu_ready || flush)) begin
        chk("alu_q_nonempty", int'(alu_q.size() != 0), 1);
        if (alu_q.size() != 0) begin
          alu_prev = alu_q.pop_front();
          if (m_alu_ready) chkp("alu_dat", mon_alu, alu_prev);
        end
      end
      alu_held = m_alu_valid & ~m_alu_ready & ~flush;
      alu_prev = mon_alu;
      for (int k = 0; k < EXU_N; k++) begin
        mon_exu = {5'd0, m_exu_msg[k*MSG_W +: MSG_W], m_exu_rd_id[k*5 +: 5]};
        if (exu_held[k]) begin
          chk($sformatf("exu%0d_hold_vld", k), int'(m_exu_valid[k]), 1);
          chkp($sformatf("exu%0d_hold_dat", k), mon_exu, exu_prev[k]);
        end
        if (m_exu_valid[k] && (m_exu_ready[k] || flush)) begin
          chk($sformatf("exu%0d_q_nonempty", k), int'(exu_q[k].size() != 0), 1);
          if (exu_q[k].size() != 0) begin
            exu_pop = exu_q[k].pop_front();
            if (m_exu_ready[k]) chkp($sformatf("exu%0d_dat", k), mon_exu, {5'd0, exu_pop});
          end
        end
        exu_held[k] = m_exu_valid[k] & ~m_exu_ready[k] & ~flush;
        exu_prev[k] = mon_exu;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    rst = 1'b1; flush = 1'b0; retire_valid = 1'b0; retire_rd_id = '0;
    m_alu_ready = 1'b1; m_exu_ready = '1;
    drive(mk(1, 32'h11, 32'h22), 4'b0000, 1'b0, 5'd5, 1'b1, ERR_NORMAL);
    step(); step();
    @(negedge clk);
    chk("rst_ready", int'(s_dsp_ready), 0);
    step();
    s_dsp_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_alu_vld", int'(m_alu_valid), 0);
    chk("rst_exu_vld", int'(m_exu_valid), 0);
    chk("rst_long_cnt", int'(long_cnt), 0);
    chk("rst_alu_msg", int'(|m_alu_msg), 0);
    chk("rst_exu_msg", int'(|m_exu_msg), 0);
    chk("rst_idle_ready", int'(s_dsp_ready), 1);
    step();

    // Plain ALU ops, back to back
    for (int i = 0; i < 3; i++) begin
      send(mk(2 + i, 32'h1000 + i, 32'h2000 + i), 4'b0000, 1'b0, 5'd5, 1'b1, ERR_NORMAL, st);
      chk("alu_b2b_stall", st, 0);
      if (i == 0) chk("alu_latency", int'(m_alu_valid), 1);
    end
    chk("alu_long_cnt", int'(long_cnt), 0);

    // WAW on rd 7 behind an outstanding MUL
    send(mk(10, 32'h7, 32'h3), 4'b0100, 1'b1, 5'd7, 1'b1, ERR_NORMAL, st);
    chk("mul_stall", st, 0);
    chk("mul_long_cnt", int'(long_cnt), 1);
    drive(mk(11, 32'h1, 32'h1), 4'b0000, 1'b0, 5'd7, 1'b1, ERR_NORMAL);
    @(negedge clk); chk("waw_stall0", int'(s_dsp_ready), 0); step();
    @(negedge clk); chk("waw_stall1", int'(s_dsp_ready), 0); step();
    retire_valid = 1'b1; retire_rd_id = 5'd7;
    @(negedge clk);
`ifdef PANDA_RISC_V_DISPATCH_RETIRE_BYPASS_EN
    chk("waw_release", int'(s_dsp_ready), 1);
    push_cur(); step();
    retire_valid = 1'b0;
`else
    chk("waw_bubble", int'(s_dsp_ready), 0);
    step();
    retire_valid = 1'b0;
    @(negedge clk);
    chk("waw_release", int'(s_dsp_ready), 1);
    push_cur(); step();
`endif
    s_dsp_valid = 1'b0;
    chk("waw_long_cnt", int'(long_cnt), 0);

    // Long cap: four loads fill it, fifth stalls
    for (int i = 1; i <= 4; i++) begin
      send(mk(20, 32'h100 * i, 32'h0), 4'b0001, 1'b1, 5'(i), 1'b1, ERR_NORMAL, st);
      chk("cap_fill_stall", st, 0);
    end
    chk("cap_long_cnt", int'(long_cnt), 4);
    drive(mk(20, 32'h500, 32'h0), 4'b0001, 1'b1, 5'd5, 1'b1, ERR_NORMAL);
    @(negedge clk);
    chk("cap_stall", int'(s_dsp_ready), 0);
    chk("cap_stall_cnt", int'(long_cnt), 4);
    step();
    retire_valid = 1'b1; retire_rd_id = 5'd1;
    @(negedge clk);
`ifdef PANDA_RISC_V_DISPATCH_RETIRE_BYPASS_EN
    chk("cap_release", int'(s_dsp_ready), 1);
    push_cur(); step();
    retire_valid = 1'b0;
`else
    chk("cap_bubble", int'(s_dsp_ready), 0);
    step();
    retire_valid = 1'b0;
    @(negedge clk);
    chk("cap_release", int'(s_dsp_ready), 1);
    push_cur(); step();
`endif
    s_dsp_valid = 1'b0;
    chk("cap_after_cnt", int'(long_cnt), 4);
    retire(5'd2);
    chk("cap_retire_cnt", int'(long_cnt), 3);
    drive(mk(21, 32'h600, 32'h0), 4'b0001, 1'b1, 5'd6, 1'b1, ERR_NORMAL);
    retire_valid = 1'b1; retire_rd_id = 5'd3;
    @(negedge clk);
    chk("acc_ret_ready", int'(s_dsp_ready), 1);
    push_cur(); step();
    retire_valid = 1'b0; s_dsp_valid = 1'b0;
    chk("acc_ret_cnt", int'(long_cnt), 3);
    retire(5'd4); retire(5'd5); retire(5'd6);
    chk("cap_drain_cnt", int'(long_cnt), 0);

    // Misaligned store and load go to the ALU only
    m_exu_ready[EXU_LSU] = 1'b0;
    send(mk(30, 32'h1003, 32'h0), 4'b0001, 1'b1, 5'd0, 1'b0, ERR_STR_ADDR_UNALIGNED, st);
    chk("mis_st_stall", st, 0);
    chk("mis_st_alu_vld", int'(m_alu_valid), 1);
    chk("mis_st_lsu_vld", int'(m_exu_valid[EXU_LSU]), 0);
    chk("mis_st_cnt", int'(long_cnt), 0);
    send(mk(31, 32'h2001, 32'h0), 4'b0001, 1'b1, 5'd3, 1'b1, ERR_LD_ADDR_UNALIGNED, st);
    chk("mis_ld_stall", st, 0);
    chk("mis_ld_lsu_vld", int'(m_exu_valid[EXU_LSU]), 0);
    chk("mis_ld_cnt", int'(long_cnt), 0);
    send(mk(32, 32'h3, 32'h3), 4'b0000, 1'b0, 5'd3, 1'b1, ERR_NORMAL, st);
    chk("mis_ld_no_busy", st, 0);
    m_exu_ready[EXU_LSU] = 1'b1;

    // Flush drops a held DIV and its ALU copy
    m_exu_ready[EXU_DIV] = 1'b0;
    send(mk(40, 32'h90, 32'h9), 4'b1000, 1'b1, 5'd9, 1'b1, ERR_NORMAL, st);
    chk("div_stall", st, 0);
    m_alu_ready = 1'b0;
    step();
    chk("div_held_vld", int'(m_exu_valid[EXU_DIV]), 1);
    chk("div_alu_held", int'(m_alu_valid), 1);
    chk("div_cnt", int'(long_cnt), 1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", int'(s_dsp_ready), 0);
    step();
    flush = 1'b0;
    chk("flush_div_vld", int'(m_exu_valid[EXU_DIV]), 0);
    chk("flush_alu_vld", int'(m_alu_valid), 0);
    chk("flush_cnt", int'(long_cnt), 1 - 1);
    m_alu_ready = 1'b1;
    m_exu_ready[EXU_DIV] = 1'b1;
    send(mk(41, 32'h9, 32'h9), 4'b0000, 1'b0, 5'd9, 1'b1, ERR_NORMAL, st);
    chk("flush_busy9_clear", st, 0);

    // Flush coinciding with the EXU handshake keeps the entry as taken
    m_exu_ready[EXU_MUL] = 1'b0;
    send(mk(42, 32'hA, 32'hA), 4'b0100, 1'b1, 5'd10, 1'b1, ERR_NORMAL, st);
    m_exu_ready[EXU_MUL] = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_taken_cnt", int'(long_cnt), 1);
    drive(mk(43, 32'h1, 32'h1), 4'b0000, 1'b0, 5'd10, 1'b1, ERR_NORMAL);
    @(negedge clk);
    chk("flush_taken_busy", int'(s_dsp_ready), 0);
    step();
    s_dsp_valid = 1'b0;
    retire(5'd10);
    chk("flush_taken_retire", int'(long_cnt), 0);

    // CSR slot stalls while the ALU slot drains on its own
    m_exu_ready[EXU_CSR] = 1'b0;
    send(mk(50, 32'h300, 32'h1), 4'b0010, 1'b0, 5'd11, 1'b1, ERR_NORMAL, st);
    chk("csr_stall", st, 0);
    step();
    chk("drain_alu_empty", int'(m_alu_valid), 0);
    chk("drain_csr_held", int'(m_exu_valid[EXU_CSR]), 1);
    step();
    drive(mk(51, 32'h301, 32'h2), 4'b0010, 1'b0, 5'd12, 1'b1, ERR_NORMAL);
    @(negedge clk); chk("csr2_stall0", int'(s_dsp_ready), 0); step();
    @(negedge clk); chk("csr2_stall1", int'(s_dsp_ready), 0); step();
    m_exu_ready[EXU_CSR] = 1'b1;
    @(negedge clk);
    chk("csr2_resume", int'(s_dsp_ready), 1);
    push_cur(); step();
    s_dsp_valid = 1'b0;

    step(); step(); step();
    chk("end_alu_q", alu_q.size(), 0);
    for (int k = 0; k < EXU_N; k++) chk($sformatf("end_exu%0d_q", k), exu_q[k].size(), 0);
    chk("end_long_cnt", int'(long_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
